burst_rom: RTL

- Parametrised successor to the image-data ROM.
- Holds a DEPTH x DW read-only array, loaded by $readmemh from the bench or by hierarchical preload.
- Serves burst read requests: start address plus length in, stream of words out.
- Uses ready/valid handshakes with full backpressure, a configurable read latency and an OE tri-state output, so CNN feature-fetch logic can stream pixels without per-word address generation.

---
 rtl/rom_pkg.sv | 29 ++
 rtl/rom_out_fifo.sv | 60 ++++++
 rtl/burst_rom.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rom_pkg.sv
// ============================================================================
// rom_pkg : shared types and helpers for the burst_rom block
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package rom_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int ENTRY_DW = 16;

  typedef struct packed {
    logic                last;
    logic [ENTRY_DW-1:0] data;
  } rom_entry_t;

  // Credit/count registers must hold 0..LAT+1 (FIFO depth is LAT+1).
  function automatic int cred_width(input int lat);
    return $clog2(lat + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rom_out_fifo.sv
// ============================================================================
// rom_out_fifo : small synchronous output FIFO with push/pop/count
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rom_out_fifo
  import rom_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter int  CW      = 2,
  parameter type entry_t = rom_entry_t
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Full+push only happens together with a pop, so the slot being
  // overwritten is always the one leaving through the head.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/burst_rom.sv
// ============================================================================
// burst_rom : read-only array serving ready/valid bursts with backpressure
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module burst_rom
  import rom_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 20,
  parameter int DEPTH = 786432,
  parameter int LAT   = 1,
  parameter int LEN_W = 8
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [AW-1:0]    REQ_ADDR,
  input  logic [LEN_W-1:0] REQ_LEN,
  input  logic             Q_READY,
  output logic             Q_VALID,
  output logic [DW-1:0]    Q,
  output logic             Q_LAST,
  input  logic             OE,
  output logic             BUSY
);

  localparam int            FIFO_D    = LAT + 1;
  localparam int            CW        = cred_width(LAT);
  localparam int            SW        = CW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } entry_t;

  logic [DW-1:0]    r_mem [DEPTH];
  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_addr;
  logic [LEN_W-1:0] r_remain;
  logic [CW-1:0]    r_inflight;
  logic [LAT-1:0]   r_pipe_vld;
  logic [LAT-1:0]   r_pipe_last;
  logic [DW-1:0]    r_pipe_data [LAT];

  logic             w_accept;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [SW-1:0]    w_occ;
  entry_t           w_push_entry;
  entry_t           w_head;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a >= LAST_ADDR) ? '0 : a + AW'(1);
  endfunction

  // Slots committed after this edge: buffered + in flight, less a pop now.
  assign w_occ    = SW'(w_count) + SW'(r_inflight) - SW'(w_pop);
  assign w_accept = REQ_VALID & REQ_READY;

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    REQ_READY   = 1'b0;
    BUSY        = 1'b1;
    w_issue     = 1'b0;
    unique case (r_state)
      IDLE: begin
        REQ_READY = 1'b1;
        BUSY      = 1'b0;
        if (REQ_VALID) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_occ < SW'(FIFO_D)) begin
          w_issue = 1'b1;
          if (r_remain == '0) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_empty && (r_inflight == '0)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      r_addr      <= '0;
      r_remain    <= '0;
      r_inflight  <= '0;
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= REQ_ADDR;
        r_remain <= REQ_LEN;
      end else if (w_issue) begin
        r_addr   <= next_addr(r_addr);
        r_remain <= r_remain - LEN_W'(1);
      end
      r_inflight     <= r_inflight + CW'(w_issue) - CW'(w_push);
      r_pipe_vld[0]  <= w_issue;
      r_pipe_last[0] <= w_issue && (r_remain == '0);
      for (int i = 1; i < LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
    end
  end

  // Array read pipeline; addresses beyond the array read as zero.
  always_ff @(posedge CK) begin
    r_pipe_data[0] <= (r_addr <= LAST_ADDR) ? r_mem[r_addr] : '0;
    for (int i = 1; i < LAT; i++) begin
      r_pipe_data[i] <= r_pipe_data[i-1];
    end
  end

  assign w_push            = r_pipe_vld[LAT-1];
  assign w_push_entry.last = r_pipe_last[LAT-1];
  assign w_push_entry.data = r_pipe_data[LAT-1];

  rom_out_fifo #(
    .DEPTH   (FIFO_D),
    .CW      (CW),
    .entry_t (entry_t)
  ) u_out_fifo (
    .clk       (CK),
    .rst_n     (RST_N),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign Q_VALID = OE & ~w_empty;
  assign w_pop   = Q_VALID & Q_READY;
  assign Q_LAST  = Q_VALID & w_head.last;
  assign Q       = OE ? (w_empty ? '0 : w_head.data) : 'z;

endmodule

`default_nettype wire
